// File: rtl/hog_bus_pkg.sv
// Shared definitions for the HOG ext_bus slave controller: address map,
// register field positions, descriptor meta-bit positions and FSM encoding.
package hog_bus_pkg;

  localparam int unsigned ADDR_DESC    = 0;
  localparam int unsigned ADDR_STATUS  = 1;
  localparam int unsigned ADDR_CTRL    = 2;
  localparam int unsigned ADDR_IRQ_CLR = 3;
  localparam int unsigned ADDR_PERF    = 4;

  localparam int unsigned CTRL_HOG_EN   = 0;
  localparam int unsigned CTRL_IRQ_EN   = 1;
  localparam int unsigned CTRL_SOFT_RST = 2;
  localparam int unsigned CTRL_THR_LSB  = 8;
  localparam int unsigned THR_WIDTH     = 8;

  localparam int unsigned STAT_EMPTY    = 16;
  localparam int unsigned STAT_OVF      = 17;
  localparam int unsigned STAT_IRQ      = 18;
  localparam int unsigned STAT_FCNT_LSB = 24;
  localparam int unsigned FCNT_WIDTH    = 8;

  localparam int unsigned IRQCLR_PEND = 0;
  localparam int unsigned IRQCLR_OVF  = 1;
  localparam int unsigned IRQCLR_PERF = 2;

  localparam int unsigned META_VALID = 127;
  localparam int unsigned META_LAST  = 126;
  localparam int unsigned META_OVF   = 125;

  localparam int unsigned PERF_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK     = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // A zero threshold disables the level interrupt entirely.
  function automatic logic thr_hit(input logic [15:0] level, input logic [THR_WIDTH-1:0] thr);
    return (thr != 8'd0) && (level >= {8'd0, thr});
  endfunction

endpackage

// File: rtl/hog_bus_irq_gen.sv
// Interrupt/status source for hog_bus_ctrl: pending flag with threshold
// edge detect, sticky overflow flag, frame counter and registered irq.
module hog_bus_irq_gen
  import hog_bus_pkg::*;
#(
  parameter int LEVEL_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_frame_done,
  input  logic                   i_overflow,
  input  logic [LEVEL_WIDTH-1:0] i_desc_level,
  input  logic [THR_WIDTH-1:0]   i_irq_thr,
  input  logic                   i_irq_en,
  input  logic                   i_clr_pending,
  input  logic                   i_clr_ovf,
  output logic                   o_irq,
  output logic                   o_irq_pending,
  output logic                   o_ovf_sticky,
  output logic [FCNT_WIDTH-1:0]  o_frame_cnt
);

  logic                  w_thr_hit;
  logic                  w_set_pending;
  logic                  r_thr_hit_d;
  logic                  r_irq_pending;
  logic                  r_ovf_sticky;
  logic                  r_irq;
  logic [FCNT_WIDTH-1:0] r_frame_cnt;

  assign w_thr_hit     = thr_hit(16'(i_desc_level), i_irq_thr);
  assign w_set_pending = i_frame_done | (w_thr_hit & ~r_thr_hit_d);

  // Flag state: a set in the same cycle as a clear always wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_thr_hit_d   <= 1'b0;
      r_irq_pending <= 1'b0;
      r_ovf_sticky  <= 1'b0;
      r_frame_cnt   <= 8'd0;
      r_irq         <= 1'b0;
    end else begin
      r_thr_hit_d <= w_thr_hit;
      if (w_set_pending) begin
        r_irq_pending <= 1'b1;
      end else if (i_clr_pending) begin
        r_irq_pending <= 1'b0;
      end
      if (i_overflow) begin
        r_ovf_sticky <= 1'b1;
      end else if (i_clr_ovf) begin
        r_ovf_sticky <= 1'b0;
      end
      if (i_frame_done) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      r_irq <= r_irq_pending & i_irq_en;
    end
  end

  assign o_irq         = r_irq;
  assign o_irq_pending = r_irq_pending;
  assign o_ovf_sticky  = r_ovf_sticky;
  assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: rtl/hog_bus_ctrl.sv
// Slave-side ext_bus controller between the HPS and the HOG descriptor FIFO.
// Optional PERF counters at address 4 are built when HOG_BUS_PERF_CNT_EN is defined.
module hog_bus_ctrl
  import hog_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int BUS_WIDTH   = 128,
  parameter int BUS_BYTES   = BUS_WIDTH / 8,
  parameter int LEVEL_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic                   bus_enable,
  input  logic                   r_wbar,
  input  logic [BUS_WIDTH-1:0]   write_data,
  input  logic [BUS_BYTES-1:0]   byte_enable,
  output logic                   ack,
  output logic [BUS_WIDTH-1:0]   read_data,
  output logic                   irq,
  input  logic [BUS_WIDTH-4:0]   desc_data,
  input  logic                   desc_last,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic [LEVEL_WIDTH-1:0] desc_level,
  input  logic                   frame_done,
  input  logic                   overflow,
  output logic                   hog_enable,
  output logic                   hog_soft_rst
);

  state_e                r_state;
  state_e                w_next_state;
  logic                  w_start;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_sel_desc;
  logic                  w_sel_status;
  logic                  w_sel_ctrl;
  logic                  w_sel_clr;
  logic                  w_wr_ctrl;
  logic                  w_pop;
  logic                  w_clr_pending;
  logic                  w_clr_ovf;
  logic [BUS_WIDTH-1:0]  w_rd_data;
  logic                  r_ack;
  logic [BUS_WIDTH-1:0]  r_read_data;
  logic                  r_hog_enable;
  logic                  r_irq_en;
  logic                  r_hog_soft_rst;
  logic [THR_WIDTH-1:0]  r_irq_thr;
  logic                  w_irq;
  logic                  w_irq_pending;
  logic                  w_ovf_sticky;
  logic [FCNT_WIDTH-1:0] w_frame_cnt;
  logic                  w_unused;

  assign w_sel_desc    = (addr == ADDR_WIDTH'(ADDR_DESC));
  assign w_sel_status  = (addr == ADDR_WIDTH'(ADDR_STATUS));
  assign w_sel_ctrl    = (addr == ADDR_WIDTH'(ADDR_CTRL));
  assign w_sel_clr     = (addr == ADDR_WIDTH'(ADDR_IRQ_CLR));
  assign w_rd          = w_start & r_wbar;
  assign w_wr          = w_start & ~r_wbar;
  assign w_wr_ctrl     = w_wr & w_sel_ctrl;
  assign w_pop         = w_rd & w_sel_desc & desc_valid;
  assign w_clr_pending = w_wr & w_sel_clr & write_data[IRQCLR_PEND];
  assign w_clr_ovf     = w_wr & w_sel_clr & write_data[IRQCLR_OVF];
  assign w_unused      = ^{write_data[BUS_WIDTH-1:16], write_data[7:2], byte_enable[BUS_BYTES-1:2],
                           w_sel_status};

  // State register for the request/ack/release handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state; an access executes only on the IDLE cycle that sees bus_enable.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus_enable && !rst) begin
          w_start      = 1'b1;
          w_next_state = ST_ACK;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ACK: begin
        w_next_state = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!bus_enable) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RELEASE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

`ifdef HOG_BUS_PERF_CNT_EN
  logic [PERF_CNT_WIDTH-1:0] r_pop_cnt;
  logic [PERF_CNT_WIDTH-1:0] r_empty_cnt;
  logic                      w_clr_perf;
  logic                      w_empty_rd;

  assign w_clr_perf = w_wr & w_sel_clr & write_data[IRQCLR_PERF];
  assign w_empty_rd = w_rd & w_sel_desc & ~desc_valid;

  // Saturating pop / empty-read counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pop_cnt   <= 32'd0;
      r_empty_cnt <= 32'd0;
    end else if (w_clr_perf) begin
      r_pop_cnt   <= 32'd0;
      r_empty_cnt <= 32'd0;
    end else begin
      if (w_pop && (r_pop_cnt != 32'hFFFF_FFFF)) begin
        r_pop_cnt <= r_pop_cnt + 32'd1;
      end
      if (w_empty_rd && (r_empty_cnt != 32'hFFFF_FFFF)) begin
        r_empty_cnt <= r_empty_cnt + 32'd1;
      end
    end
  end
`endif

  // Read-data mux, evaluated on the request cycle.
  always_comb begin
    w_rd_data = '0;
    case (addr)
      ADDR_WIDTH'(ADDR_DESC): begin
        w_rd_data[META_VALID] = desc_valid;
        w_rd_data[META_LAST]  = desc_valid & desc_last;
        w_rd_data[META_OVF]   = w_ovf_sticky;
        if (desc_valid) begin
          w_rd_data[BUS_WIDTH-4:0] = desc_data;
        end else begin
          w_rd_data[BUS_WIDTH-4:0] = '0;
        end
      end
      ADDR_WIDTH'(ADDR_STATUS): begin
        w_rd_data[LEVEL_WIDTH-1:0]                 = desc_level;
        w_rd_data[STAT_EMPTY]                      = ~desc_valid;
        w_rd_data[STAT_OVF]                        = w_ovf_sticky;
        w_rd_data[STAT_IRQ]                        = w_irq_pending;
        w_rd_data[STAT_FCNT_LSB +: FCNT_WIDTH]     = w_frame_cnt;
      end
      ADDR_WIDTH'(ADDR_CTRL): begin
        w_rd_data[CTRL_HOG_EN]                 = r_hog_enable;
        w_rd_data[CTRL_IRQ_EN]                 = r_irq_en;
        w_rd_data[CTRL_THR_LSB +: THR_WIDTH]   = r_irq_thr;
      end
`ifdef HOG_BUS_PERF_CNT_EN
      ADDR_WIDTH'(ADDR_PERF): begin
        w_rd_data[31:0]  = r_pop_cnt;
        w_rd_data[63:32] = r_empty_cnt;
      end
`endif
      default: begin
        w_rd_data = '0;
      end
    endcase
  end

  // Bus response: ack and read data launch on the closing edge of the request cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack       <= 1'b0;
      r_read_data <= '0;
    end else begin
      r_ack <= w_start;
      if (w_start) begin
        r_read_data <= r_wbar ? w_rd_data : '0;
      end
    end
  end

  // CTRL register with per-byte write enables; soft_rst is a self-clearing pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hog_enable   <= 1'b0;
      r_irq_en       <= 1'b0;
      r_irq_thr      <= 8'd0;
      r_hog_soft_rst <= 1'b0;
    end else begin
      r_hog_soft_rst <= w_wr_ctrl & byte_enable[0] & write_data[CTRL_SOFT_RST];
      if (w_wr_ctrl && byte_enable[0]) begin
        r_hog_enable <= write_data[CTRL_HOG_EN];
        r_irq_en     <= write_data[CTRL_IRQ_EN];
      end
      if (w_wr_ctrl && byte_enable[1]) begin
        r_irq_thr <= write_data[CTRL_THR_LSB +: THR_WIDTH];
      end
    end
  end

  hog_bus_irq_gen #(
    .LEVEL_WIDTH (LEVEL_WIDTH)
  ) u_irq_gen (
    .clk           (clk),
    .rst           (rst),
    .i_frame_done  (frame_done),
    .i_overflow    (overflow),
    .i_desc_level  (desc_level),
    .i_irq_thr     (r_irq_thr),
    .i_irq_en      (r_irq_en),
    .i_clr_pending (w_clr_pending),
    .i_clr_ovf     (w_clr_ovf),
    .o_irq         (w_irq),
    .o_irq_pending (w_irq_pending),
    .o_ovf_sticky  (w_ovf_sticky),
    .o_frame_cnt   (w_frame_cnt)
  );

  assign ack          = r_ack;
  assign read_data    = r_read_data;
  assign irq          = w_irq;
  assign desc_ready   = w_pop;
  assign hog_enable   = r_hog_enable;
  assign hog_soft_rst = r_hog_soft_rst;

endmodule

// File: tb/tb_hog_bus_ctrl.sv
// Self-checking bench for hog_bus_ctrl: a register-map level model compared
// every cycle, plus directed transactions with hand-computed expectations.
module tb_hog_bus_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   addr = 5'd0;
  logic         bus_enable = 1'b0;
  logic         r_wbar = 1'b1;
  logic [127:0] write_data = 128'd0;
  logic [15:0]  byte_enable = 16'd0;
  logic         ack;
  logic [127:0] read_data;
  logic         irq;
  logic [124:0] desc_data = 125'd0;
  logic         desc_last = 1'b0;
  logic         desc_valid = 1'b0;
  logic         desc_ready;
  logic [9:0]   desc_level = 10'd0;
  logic         frame_done = 1'b0;
  logic         overflow = 1'b0;
  logic         hog_enable;
  logic         hog_soft_rst;

  int n_checks = 0;
  int n_fail   = 0;
  int pops     = 0;

  always #5 clk = ~clk;

  hog_bus_ctrl #(.ADDR_WIDTH(5), .BUS_WIDTH(128), .BUS_BYTES(16), .LEVEL_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .addr(addr), .bus_enable(bus_enable), .r_wbar(r_wbar),
    .write_data(write_data), .byte_enable(byte_enable), .ack(ack), .read_data(read_data),
    .irq(irq), .desc_data(desc_data), .desc_last(desc_last), .desc_valid(desc_valid),
    .desc_ready(desc_ready), .desc_level(desc_level), .frame_done(frame_done),
    .overflow(overflow), .hog_enable(hog_enable), .hog_soft_rst(hog_soft_rst)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Descriptor FIFO: entries are {last, data}; head popped on desc_ready.
  logic [125:0] fifo_q[$];

  task automatic update_head();
    desc_valid = (fifo_q.size() > 0);
    if (fifo_q.size() > 0) {desc_last, desc_data} = fifo_q[0];
    else {desc_last, desc_data} = 126'd0;
  endtask

  always @(posedge clk) begin
    if (desc_ready === 1'b1 && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    #1 update_head();
  end

  // Register-map model state.
  logic         m_idle, m_ack, m_hog_en, m_irq_en, m_soft, m_pend, m_ovf, m_irq, m_hit_prev;
  logic [7:0]   m_thr, m_fcnt;
  logic [127:0] m_rdata;
  logic         t_start, t_hit, t_setp, t_clrp, t_clro;

  function automatic logic [127:0] model_read(input logic [4:0] a);
    logic [127:0] v = 128'd0;
    case (a)
      5'd0: v = desc_valid ? {1'b1, desc_last, m_ovf, desc_data} : {2'b00, m_ovf, 125'd0};
      5'd1: begin v[9:0] = desc_level; v[16] = ~desc_valid; v[17] = m_ovf; v[18] = m_pend; v[31:24] = m_fcnt; end
      5'd2: begin v[0] = m_hog_en; v[1] = m_irq_en; v[15:8] = m_thr; end
      default: v = 128'd0;
    endcase
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle = 1'b1; m_ack = 1'b0; m_hog_en = 1'b0; m_irq_en = 1'b0; m_soft = 1'b0;
      m_pend = 1'b0; m_ovf = 1'b0; m_irq = 1'b0; m_hit_prev = 1'b0;
      m_thr = 8'd0; m_fcnt = 8'd0; m_rdata = 128'd0;
    end else begin
      t_start = m_idle && bus_enable;
      t_hit   = (m_thr != 8'd0) && (desc_level >= {2'b00, m_thr});
      t_setp  = frame_done || (t_hit && !m_hit_prev);
      t_clrp  = t_start && !r_wbar && addr == 5'd3 && write_data[0];
      t_clro  = t_start && !r_wbar && addr == 5'd3 && write_data[1];
      if (t_start) m_rdata = r_wbar ? model_read(addr) : 128'd0;
      m_irq  = m_pend & m_irq_en;
      m_soft = 1'b0;
      if (t_start && !r_wbar && addr == 5'd2) begin
        if (byte_enable[0]) begin
          m_hog_en = write_data[0]; m_irq_en = write_data[1]; m_soft = write_data[2];
        end
        if (byte_enable[1]) m_thr = write_data[15:8];
      end
      if (t_setp) m_pend = 1'b1; else if (t_clrp) m_pend = 1'b0;
      if (overflow) m_ovf = 1'b1; else if (t_clro) m_ovf = 1'b0;
      if (frame_done) m_fcnt = m_fcnt + 8'd1;
      m_hit_prev = t_hit;
      if (t_start) begin
        m_idle = 1'b0; m_ack = 1'b1;
      end else begin
        if (!m_ack && !m_idle && !bus_enable) m_idle = 1'b1;
        m_ack = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("ack", ack, m_ack);
    check("read_data", read_data, m_rdata);
    check("desc_ready", desc_ready, m_idle && bus_enable && r_wbar && addr == 5'd0 && desc_valid && !rst);
    check("irq", irq, m_irq);
    check("hog_enable", hog_enable, m_hog_en);
    check("hog_soft_rst", hog_soft_rst, m_soft);
  end

  task automatic bus_xfer(input logic wr, input logic [4:0] a, input logic [127:0] wd,
                          input logic [15:0] be, input logic ovf, output logic [127:0] rd);
    bit got = 1'b0;
    rd = 128'd0;
    @(posedge clk); #1;
    bus_enable = 1'b1; r_wbar = ~wr; addr = a; write_data = wd; byte_enable = be; overflow = ovf;
    @(posedge clk); #1;
    overflow = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (ack === 1'b1) begin got = 1'b1; rd = read_data; end
    end
    check("ack_seen", got, 1'b1);
    @(posedge clk); #1;
    bus_enable = 1'b0; write_data = 128'd0; byte_enable = 16'd0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rd;
    logic [124:0] da, db;
    int acks;
    int pops0;
    da = 125'h1_2345_6789_ABCD;
    db = 125'h0_DEAD_BEEF;

    repeat (3) @(negedge clk);
    check("rst_ack", ack, 1'b0);
    check("rst_read_data", read_data, 128'd0);
    check("rst_irq", irq, 1'b0);
    check("rst_hog_enable", hog_enable, 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    fifo_q.push_back({1'b0, da});
    fifo_q.push_back({1'b1, db});
    update_head();
    bus_xfer(1'b0, 5'd0, 128'd0, 16'd0, 1'b0, rd);
    check("desc0_meta", rd[127:125], 3'b100);
    check("desc0_data", rd[124:0], da);
    bus_xfer(1'b0, 5'd0, 128'd0, 16'd0, 1'b0, rd);
    check("desc1_meta", rd[127:125], 3'b110);
    check("desc1_data", rd[124:0], db);
    check("pops_two", pops, 2);

    bus_xfer(1'b0, 5'd0, 128'd0, 16'd0, 1'b0, rd);
    check("desc_empty", rd, 128'd0);
    check("pops_empty", pops, 2);

    bus_xfer(1'b1, 5'd2, 128'h0503, 16'h0001, 1'b0, rd);
    bus_xfer(1'b0, 5'd2, 128'd0, 16'd0, 1'b0, rd);
    check("ctrl_byte0", rd, 128'h3);
    bus_xfer(1'b1, 5'd2, 128'h0507, 16'hFFFF, 1'b0, rd);
    bus_xfer(1'b0, 5'd2, 128'd0, 16'd0, 1'b0, rd);
    check("ctrl_full", rd, 128'h503);

    check("irq_before_ramp", irq, 1'b0);
    for (int lv = 3; lv <= 6; lv++) begin
      @(posedge clk); #1 desc_level = 10'(lv);
    end
    repeat (3) @(negedge clk);
    check("irq_after_ramp", irq, 1'b1);
    bus_xfer(1'b1, 5'd3, 128'h1, 16'hFFFF, 1'b0, rd);
    repeat (3) @(negedge clk);
    check("irq_cleared", irq, 1'b0);
    bus_xfer(1'b0, 5'd1, 128'd0, 16'd0, 1'b0, rd);
    check("status_level6", rd, 128'h0001_0006);
    @(posedge clk); #1 desc_level = 10'd0;

    bus_xfer(1'b0, 5'd4, 128'd0, 16'd0, 1'b0, rd);
    check("unmapped4", rd, 128'd0);
    bus_xfer(1'b1, 5'd1, 128'hFFFF, 16'hFFFF, 1'b0, rd);
    bus_xfer(1'b0, 5'd17, 128'd0, 16'd0, 1'b0, rd);
    check("unmapped17", rd, 128'd0);

    fifo_q.push_back({1'b1, 125'h55});
    update_head();
    pops0 = pops;
    bus_xfer(1'b1, 5'd0, 128'hFF, 16'hFFFF, 1'b0, rd);
    check("write_desc_nopop", pops, pops0);
    @(posedge clk); #1;
    bus_enable = 1'b1; r_wbar = 1'b1; addr = 5'd0;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    @(posedge clk); #1 bus_enable = 1'b0;
    repeat (3) @(posedge clk);
    check("hold_acks", acks, 1);
    check("hold_pops", pops, pops0 + 1);

    bus_xfer(1'b1, 5'd3, 128'h2, 16'hFFFF, 1'b1, rd);
    bus_xfer(1'b0, 5'd1, 128'd0, 16'd0, 1'b0, rd);
    check("ovf_set_wins", rd[17], 1'b1);
    bus_xfer(1'b1, 5'd3, 128'h2, 16'hFFFF, 1'b0, rd);
    bus_xfer(1'b0, 5'd1, 128'd0, 16'd0, 1'b0, rd);
    check("ovf_cleared", rd[17], 1'b0);

    @(posedge clk); #1 frame_done = 1'b1;
    repeat (3) @(posedge clk);
    #1 frame_done = 1'b0;
    bus_xfer(1'b0, 5'd1, 128'd0, 16'd0, 1'b0, rd);
    check("frame_cnt3", rd[31:24], 8'd3);
    @(posedge clk); #1 frame_done = 1'b1;
    repeat (253) @(posedge clk);
    #1 frame_done = 1'b0;
    bus_xfer(1'b0, 5'd1, 128'd0, 16'd0, 1'b0, rd);
    check("frame_cnt_wrap", rd[31:24], 8'd0);
    check("irq_frame", irq, 1'b1);

    @(posedge clk); #1;
    bus_enable = 1'b1; r_wbar = 1'b1; addr = 5'd2;
    @(posedge clk); #1;
    check("ack_before_rst", ack, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid_ack", ack, 1'b0);
    check("rst_mid_hog_enable", hog_enable, 1'b0);
    check("rst_mid_read_data", read_data, 128'd0);
    check("rst_mid_irq", irq, 1'b0);
    bus_enable = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    bus_xfer(1'b0, 5'd2, 128'd0, 16'd0, 1'b0, rd);
    check("ctrl_after_rst", rd, 128'd0);
    bus_xfer(1'b0, 5'd1, 128'd0, 16'd0, 1'b0, rd);
    check("status_after_rst", rd, 128'h0001_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hog_bus_ctrl.md
Name: hog_bus_ctrl

Overview:
Slave-side controller for the 128-bit ext_bus between the HPS block and the HOG pipeline.
- Decodes bus transactions and generates ack.
- Pops descriptor words from the HOG output FIFO and tags them with 3 meta bits.
- Holds control/status registers and drives irq to the HPS.
- Sits in the clk_slow domain between the descriptor FIFO and the hps_block bus pins.

Parameters:
ADDR_WIDTH, 5, bus word-address width
BUS_WIDTH, 128, bus data width; upper 3 bits are meta
BUS_BYTES, BUS_WIDTH/8, byte-enable width
LEVEL_WIDTH, 10, FIFO fill-level width

Ports:
clk  in  1  block clock (clk_slow domain)
rst  in  1  asynchronous, active-high reset
addr  in  ADDR_WIDTH  word address
bus_enable  in  1  transaction request
r_wbar  in  1  1=read, 0=write
write_data  in  BUS_WIDTH  write data
byte_enable  in  BUS_BYTES  per-byte write enable
ack  out  1  one-cycle transaction acknowledge
read_data  out  BUS_WIDTH  registered read data
irq  out  1  level interrupt to HPS
desc_data  in  BUS_WIDTH-3  FIFO head descriptor
desc_last  in  1  head word is last of frame
desc_valid  in  1  FIFO non-empty
desc_ready  out  1  pop strobe
desc_level  in  LEVEL_WIDTH  FIFO fill level
frame_done  in  1  pulse, frame finished by pipeline
overflow  in  1  pulse, FIFO dropped a word
hog_enable  out  1  pipeline run enable
hog_soft_rst  out  1  one-cycle pipeline soft reset

Behaviour:
- Reset: ack=0, read_data=0, irq=0, desc_ready=0, hog_enable=0, hog_soft_rst=0, all registers 0, FSM=IDLE.
- FSM states: IDLE, ACK, RELEASE.
  - IDLE: on bus_enable=1, execute the access, then go to ACK.
  - ACK: drive ack=1 for exactly one cycle with read_data valid, then go to RELEASE.
  - RELEASE: wait for bus_enable=0, then go to IDLE.
  - Result: one transaction per bus_enable assertion. Latency is request cycle N to ack at N+1.
- Register map (word addresses):
  - 0 DESC (R): if desc_valid, pulse desc_ready for 1 cycle in cycle N. read_data = {1'b1, desc_last, ovf_sticky, desc_data}. If empty: no pop, read_data = {1'b0, 1'b0, ovf_sticky, 0}.
  - 1 STATUS (R): [LEVEL_WIDTH-1:0]=desc_level, [16]=~desc_valid, [17]=ovf_sticky, [18]=irq_pending, [31:24]=frame_cnt. Remaining bits 0.
  - 2 CTRL (R/W): [0]=hog_enable, [1]=irq_en, [2]=soft_rst, [15:8]=irq_thr. Write honours byte_enable. soft_rst reads 0 and pulses hog_soft_rst for 1 cycle at N+1.
  - 3 IRQ_CLR (W): bit0=1 clears irq_pending; bit1=1 clears ovf_sticky. Reads return 0.
  - Unmapped addresses: reads return 0, writes are ignored, ack is still given.
  - Writes to read-only addresses and reads of DESC from the write path (r_wbar=0 to addr 0) have no side effect, and no pop.
- irq_pending set conditions:
  - frame_done pulse, or
  - rising edge of (irq_thr!=0 && desc_level>=irq_thr).
- If set and clear occur in the same cycle, set wins.
- irq = irq_pending & irq_en (registered).
- ovf_sticky sets on overflow. If set and clear occur in the same cycle, set wins.
- frame_cnt: 8-bit, increments on frame_done, wraps 255→0.
- bus_enable held high past RELEASE never re-triggers.
- Reset mid-transaction aborts to IDLE with no ack.

Optional Feature:
HOG_BUS_PERF_CNT_EN
- Defined: adds address 4 PERF (R). [31:0]=successful pop count, [63:32]=empty-DESC-read count; both saturate at 2^32-1. IRQ_CLR bit2=1 clears both counters.
- Undefined: address 4 behaves as unmapped, and IRQ_CLR bit2 is ignored.

Decomposition:
- Package hog_bus_pkg holds:
  - address constants ADDR_DESC/STATUS/CTRL/IRQ_CLR/PERF
  - CTRL and STATUS bit-field positions
  - meta-bit positions: META_VALID=127, META_LAST=126, META_OVF=125
  - FSM state encoding
- Sub-module hog_bus_irq_gen holds irq_pending, threshold edge detect, ovf_sticky and frame_cnt. The FSM/decoder stays in the top module.

Test Plan:
- FIFO holds 2 words (second with desc_last=1); issue 2 reads at addr 0 → two acks. meta = 3'b100 then 3'b110, exactly one desc_ready pulse per read.
- Empty FIFO, read addr 0 → ack at N+1, meta = 3'b000, data 0, desc_ready never asserted.
- Write CTRL=0x0000_0503 with byte_enable=16'h0001 → hog_enable=1, irq_en=1, irq_thr stays 0. Then full byte_enable → irq_thr=5.
- irq_thr=5, irq_en=1; desc_level ramps 3→6 → irq=1 within 2 cycles. Write IRQ_CLR=1 → irq=0. Level held at 6 → no re-trigger.
- bus_enable held high for 10 cycles on a read → exactly one ack and one pop. Assert rst during ACK → ack=0 immediately, all registers 0.
- overflow pulse coincident with IRQ_CLR bit1 write → ovf_sticky stays 1. frame_done x256 → frame_cnt wraps to 0.
